// File: rtl/up_down_counter_mod_if.sv
// ---------------------------------------------------------------------------
// up_down_counter_mod_if
// Purpose : Groups the control inputs and status outputs of the bounded
//           up/down counter into one bundle, so the counter and whatever
//           drives it share a single connection point.
// Signals : i_clear      sync clear of count and sticky flags
//           i_load       sync parallel load of i_loadVal
//           i_loadVal    value to load (clamped into the count range)
//           i_enable     count step enable
//           i_upDown     1 = count up, 0 = count down
//           i_satMode    1 = saturate at bounds, 0 = wrap between bounds
//           o_count      current count
//           o_atMax      count equals the upper bound
//           o_atMin      count equals the lower bound
//           o_wrapPulse  one-cycle pulse in the cycle after a wrap
//           o_ovfSticky  up-step was attempted at the upper bound
//           o_unfSticky  down-step was attempted at the lower bound
// Modports: master drives the controls (controller / testbench),
//           slave is the counter itself.
// ---------------------------------------------------------------------------
interface up_down_counter_mod_if #(
    parameter int WIDTH = 4
);
    logic             i_clear;
    logic             i_load;
    logic [WIDTH-1:0] i_loadVal;
    logic             i_enable;
    logic             i_upDown;
    logic             i_satMode;
    logic [WIDTH-1:0] o_count;
    logic             o_atMax;
    logic             o_atMin;
    logic             o_wrapPulse;
    logic             o_ovfSticky;
    logic             o_unfSticky;

    modport master (
        output i_clear, i_load, i_loadVal, i_enable, i_upDown, i_satMode,
        input  o_count, o_atMax, o_atMin, o_wrapPulse, o_ovfSticky, o_unfSticky
    );

    modport slave (
        input  i_clear, i_load, i_loadVal, i_enable, i_upDown, i_satMode,
        output o_count, o_atMax, o_atMin, o_wrapPulse, o_ovfSticky, o_unfSticky
    );
endinterface

// File: rtl/up_down_counter_mod.sv
// ---------------------------------------------------------------------------
// up_down_counter_mod
// Purpose : Bounded up/down counter over [MIN_VAL, MAX_VAL] with runtime
//           wrap/saturate selection, synchronous clear, clamped parallel
//           load, registered terminal-count flags, a registered wrap pulse
//           and sticky overflow/underflow flags. All outputs registered.
// Params  : WIDTH   counter width in bits (>= 2)
//           MIN_VAL lower bound of the count range
//           MAX_VAL upper bound; MIN_VAL < MAX_VAL <= 2**WIDTH-1
// Ports   : clk      rising-edge clock
//           reset_n  asynchronous active-low reset
//           bus      slave side of up_down_counter_mod_if (controls in,
//                    count and status flags out)
// ---------------------------------------------------------------------------
module up_down_counter_mod #(
    parameter int WIDTH   = 4,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 2**WIDTH - 1
) (
    input logic                  clk,
    input logic                  reset_n,
    up_down_counter_mod_if.slave bus
);

    localparam logic [WIDTH-1:0] L_MIN = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_atMax;
    logic             r_atMin;
    logic             r_wrapPulse;
    logic             r_ovfSticky;
    logic             r_unfSticky;

    logic [WIDTH-1:0] w_loadClamped;
    logic [WIDTH-1:0] w_nextCount;
    logic             w_nextWrap;
    logic             w_nextOvf;
    logic             w_nextUnf;

    // Load value is forced into the legal range so a bad load can never
    // push the count outside [MIN_VAL, MAX_VAL].
    always_comb begin
        w_loadClamped = bus.i_loadVal;
        if (bus.i_loadVal <= L_MIN) begin
            w_loadClamped = L_MIN;
        end else if (bus.i_loadVal >= L_MAX) begin
            w_loadClamped = L_MAX;
        end
    end

    // Next-state selection with priority clear > load > step > hold.
    // The bound is checked before stepping, so the WIDTH-bit add/subtract
    // never rolls over past 2**WIDTH; wrapping is done explicitly to the
    // opposite bound, and saturation simply keeps the current value.
    always_comb begin
        w_nextCount = r_count;
        w_nextWrap  = 1'b0;
        w_nextOvf   = r_ovfSticky;
        w_nextUnf   = r_unfSticky;
        if (bus.i_clear) begin
            w_nextCount = L_MIN;
            w_nextOvf   = 1'b0;
            w_nextUnf   = 1'b0;
        end else if (bus.i_load) begin
            w_nextCount = w_loadClamped;
        end else if (bus.i_enable) begin
            if (bus.i_upDown) begin
                if (r_count == L_MAX) begin
                    w_nextOvf = 1'b1;
                    if (!bus.i_satMode) begin
                        w_nextCount = L_MIN;
                        w_nextWrap  = 1'b1;
                    end
                end else begin
                    w_nextCount = r_count + WIDTH'(1);
                end
            end else begin
                if (r_count == L_MIN) begin
                    w_nextUnf = 1'b1;
                    if (!bus.i_satMode) begin
                        w_nextCount = L_MAX;
                        w_nextWrap  = 1'b1;
                    end
                end else begin
                    w_nextCount = r_count - WIDTH'(1);
                end
            end
        end
    end

    // State registers. The terminal-count flags are derived from the next
    // count so they always line up with the registered count value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count     <= L_MIN;
            r_atMax     <= 1'b0;
            r_atMin     <= 1'b1;
            r_wrapPulse <= 1'b0;
            r_ovfSticky <= 1'b0;
            r_unfSticky <= 1'b0;
        end else begin
            r_count     <= w_nextCount;
            r_atMax     <= (w_nextCount == L_MAX);
            r_atMin     <= (w_nextCount == L_MIN);
            r_wrapPulse <= w_nextWrap;
            r_ovfSticky <= w_nextOvf;
            r_unfSticky <= w_nextUnf;
        end
    end

    assign bus.o_count     = r_count;
    assign bus.o_atMax     = r_atMax;
    assign bus.o_atMin     = r_atMin;
    assign bus.o_wrapPulse = r_wrapPulse;
    assign bus.o_ovfSticky = r_ovfSticky;
    assign bus.o_unfSticky = r_unfSticky;

endmodule

// File: tb/tb_up_down_counter_mod.sv
// ---------------------------------------------------------------------------
// tb_up_down_counter_mod
// Purpose : Self-checking bench for up_down_counter_mod. The main instance
//           uses WIDTH=4, range 0..9 and is compared every cycle against a
//           behavioural model; a second instance with range 2..9 covers the
//           non-zero lower bound with literal expectations.
// ---------------------------------------------------------------------------
module tb_up_down_counter_mod;

    localparam int MODEL_MIN = 0;
    localparam int MODEL_MAX = 9;

    logic clk;
    logic reset_n;

    int checks;
    int errors;

    int mCount;
    bit mWrap;
    bit mOvf;
    bit mUnf;

    int pulseCount;

    up_down_counter_mod_if #(.WIDTH(4)) bus ();
    up_down_counter_mod_if #(.WIDTH(4)) bus2 ();

    up_down_counter_mod #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(9)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    up_down_counter_mod #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(9)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point used by every check in the bench.
    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Behavioural reference: counts as a plain integer inside the range and
    // applies the bound rules directly.
    task automatic modelReset();
        mCount = MODEL_MIN;
        mWrap  = 1'b0;
        mOvf   = 1'b0;
        mUnf   = 1'b0;
    endtask

    task automatic modelStep(input bit clr, input bit ld, input int lv,
                             input bit en, input bit ud, input bit sat);
        mWrap = 1'b0;
        if (clr) begin
            mCount = MODEL_MIN;
            mOvf   = 1'b0;
            mUnf   = 1'b0;
        end else if (ld) begin
            mCount = (lv < MODEL_MIN) ? MODEL_MIN : ((lv > MODEL_MAX) ? MODEL_MAX : lv);
        end else if (en && ud) begin
            if (mCount + 1 > MODEL_MAX) begin
                mOvf = 1'b1;
                if (!sat) begin
                    mCount = MODEL_MIN;
                    mWrap  = 1'b1;
                end
            end else begin
                mCount = mCount + 1;
            end
        end else if (en) begin
            if (mCount - 1 < MODEL_MIN) begin
                mUnf = 1'b1;
                if (!sat) begin
                    mCount = MODEL_MAX;
                    mWrap  = 1'b1;
                end
            end else begin
                mCount = mCount - 1;
            end
        end
    endtask

    // Compare every output of the main instance with the model.
    task automatic checkOutput();
        checkValue("count", int'(bus.o_count), mCount);
        checkValue("at_max", int'(bus.o_atMax), int'(mCount == MODEL_MAX));
        checkValue("at_min", int'(bus.o_atMin), int'(mCount == MODEL_MIN));
        checkValue("wrap_pulse", int'(bus.o_wrapPulse), int'(mWrap));
        checkValue("ovf_sticky", int'(bus.o_ovfSticky), int'(mOvf));
        checkValue("unf_sticky", int'(bus.o_unfSticky), int'(mUnf));
        if (bus.o_wrapPulse) pulseCount++;
    endtask

    // Drive one cycle of controls from a falling edge, advance the model at
    // the rising edge, then compare at the next falling edge.
    task automatic applyStimulus(input bit clr, input bit ld, input logic [3:0] lv,
                                 input bit en, input bit ud, input bit sat);
        bus.i_clear   = clr;
        bus.i_load    = ld;
        bus.i_loadVal = lv;
        bus.i_enable  = en;
        bus.i_upDown  = ud;
        bus.i_satMode = sat;
        @(posedge clk);
        modelStep(clr, ld, int'(lv), en, ud, sat);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic applyStimulus2(input bit ld, input logic [3:0] lv,
                                  input bit en, input bit ud, input bit sat);
        bus2.i_clear   = 1'b0;
        bus2.i_load    = ld;
        bus2.i_loadVal = lv;
        bus2.i_enable  = en;
        bus2.i_upDown  = ud;
        bus2.i_satMode = sat;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Directed sequences followed by a randomised soak against the model.
    initial begin
        int upSeq [12];
        int downSeq [5];
        checks     = 0;
        errors     = 0;
        pulseCount = 0;
        upSeq   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        downSeq = '{2, 1, 0, 9, 8};

        reset_n = 1'b0;
        bus.i_clear = 1'b0; bus.i_load = 1'b0; bus.i_loadVal = '0;
        bus.i_enable = 1'b0; bus.i_upDown = 1'b0; bus.i_satMode = 1'b0;
        bus2.i_clear = 1'b0; bus2.i_load = 1'b0; bus2.i_loadVal = '0;
        bus2.i_enable = 1'b0; bus2.i_upDown = 1'b0; bus2.i_satMode = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkValue("reset count", int'(bus.o_count), 0);
        checkValue("reset at_min", int'(bus.o_atMin), 1);
        checkValue("reset at_max", int'(bus.o_atMax), 0);
        checkValue("reset wrap_pulse", int'(bus.o_wrapPulse), 0);
        checkValue("reset ovf", int'(bus.o_ovfSticky), 0);
        checkValue("reset unf", int'(bus.o_unfSticky), 0);
        checkValue("reset count2", int'(bus2.o_count), 2);
        reset_n = 1'b1;

        $display("[TB] Test 1: count up with wrap");
        pulseCount = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
            checkValue("t1 count", int'(bus.o_count), upSeq[i]);
            checkValue("t1 pulse", int'(bus.o_wrapPulse), int'(i == 9));
            checkValue("t1 at_max", int'(bus.o_atMax), int'(i == 8));
        end
        checkValue("t1 ovf", int'(bus.o_ovfSticky), 1);
        checkValue("t1 pulse total", pulseCount, 1);

        $display("[TB] Test 2: load then count down with wrap");
        applyStimulus(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        checkValue("t2 load", int'(bus.o_count), 3);
        pulseCount = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
            checkValue("t2 count", int'(bus.o_count), downSeq[i]);
        end
        checkValue("t2 unf", int'(bus.o_unfSticky), 1);
        checkValue("t2 pulse total", pulseCount, 1);

        $display("[TB] Test 3: saturate at both bounds");
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        checkValue("t3 clear ovf", int'(bus.o_ovfSticky), 0);
        checkValue("t3 clear unf", int'(bus.o_unfSticky), 0);
        applyStimulus(1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b1);
        pulseCount = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
            checkValue("t3 sat up", int'(bus.o_count), 9);
        end
        checkValue("t3 ovf", int'(bus.o_ovfSticky), 1);
        checkValue("t3 unf untouched", int'(bus.o_unfSticky), 0);
        checkValue("t3 no pulse", pulseCount, 0);
        applyStimulus(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
            checkValue("t3 sat down", int'(bus.o_count), 0);
        end
        checkValue("t3 unf", int'(bus.o_unfSticky), 1);

        $display("[TB] Test 4: load clamping and load priority");
        applyStimulus(1'b0, 1'b1, 4'd14, 1'b0, 1'b0, 1'b0);
        checkValue("t4 clamp high", int'(bus.o_count), 9);
        checkValue("t4 clamp at_max", int'(bus.o_atMax), 1);
        applyStimulus(1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0);
        checkValue("t4 load beats step", int'(bus.o_count), 5);
        applyStimulus2(1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        checkValue("t4 min2 clamp low", int'(bus2.o_count), 2);
        checkValue("t4 min2 at_min", int'(bus2.o_atMin), 1);
        applyStimulus2(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        checkValue("t4 min2 wrap down", int'(bus2.o_count), 9);
        checkValue("t4 min2 pulse", int'(bus2.o_wrapPulse), 1);
        checkValue("t4 min2 unf", int'(bus2.o_unfSticky), 1);
        applyStimulus2(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        checkValue("t4 min2 wrap up", int'(bus2.o_count), 2);
        checkValue("t4 min2 ovf", int'(bus2.o_ovfSticky), 1);
        applyStimulus2(1'b1, 4'd13, 1'b1, 1'b1, 1'b0);
        checkValue("t4 min2 clamp high", int'(bus2.o_count), 9);
        checkValue("t4 min2 no pulse", int'(bus2.o_wrapPulse), 0);
        applyStimulus2(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] Test 5: clear priority and async reset");
        applyStimulus(1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0);
        checkValue("t5 clear count", int'(bus.o_count), 0);
        checkValue("t5 clear ovf", int'(bus.o_ovfSticky), 0);
        checkValue("t5 clear unf", int'(bus.o_unfSticky), 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        end
        checkValue("t5 pre-reset count", int'(bus.o_count), 4);
        @(posedge clk);
        modelStep(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        checkValue("t5 async count", int'(bus.o_count), 0);
        checkValue("t5 async at_min", int'(bus.o_atMin), 1);
        checkValue("t5 async count2", int'(bus2.o_count), 2);
        modelReset();
        @(negedge clk);
        checkOutput();
        reset_n = 1'b1;

        $display("[TB] Test 6: random soak");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(49) == 0), ($urandom_range(9) == 0),
                          4'($urandom_range(15)), ($urandom_range(3) != 0),
                          1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
